// File: rtl/spi_master_ctrl.sv
// SPI master for the SPI_RAM slave: sends 10-bit {cmd,payload} frames under SS_n and,
// for read-data frames, collects the 8-bit reply on MISO after a turnaround.
module spi_master_ctrl #(
   parameter int TURNAROUND = 2,
   parameter int GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_cmd,
   input  logic [7:0] req_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       seq_err,
   output logic       busy,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   // Handshake: a request is taken on a rising edge where req_valid && req_ready;
   // req_ready is high only in IDLE, so there is never more than one frame in flight.

   localparam int C_BIG = (TURNAROUND > GAP_CYCLES) ? TURNAROUND : GAP_CYCLES;
   localparam int C_MAX = (C_BIG > 10) ? C_BIG : 10;
   localparam int CW    = $clog2(C_MAX + 1);

   localparam logic [CW-1:0] C_SHIFT_LAST = CW'(9);
   localparam logic [CW-1:0] C_TURN_LAST  = CW'(TURNAROUND - 1);
   localparam logic [CW-1:0] C_CAP_LAST   = CW'(7);
   localparam logic [CW-1:0] C_GAP_LAST   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] C_ONE        = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_SHIFT,
      S_TURN,
      S_CAPTURE,
      S_GAP
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [9:0]      r_shift, w_shift_nxt;
   logic [1:0]      r_cmd, w_cmd_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [7:0]      r_rx, w_rx_nxt;
   logic            r_ss_n, w_ss_n_nxt;
   logic            r_mosi, w_mosi_nxt;
   logic            r_rsp_valid, w_rsp_valid_nxt;
   logic [7:0]      r_rsp_data, w_rsp_data_nxt;
   logic            r_seq_err, w_seq_err_nxt;
   logic            r_rd_pending, w_rd_pending_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_shift      <= '0;
         r_cmd        <= '0;
         r_cnt        <= '0;
         r_rx         <= '0;
         r_ss_n       <= 1'b1;
         r_mosi       <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
         r_seq_err    <= 1'b0;
         r_rd_pending <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_cmd        <= w_cmd_nxt;
         r_cnt        <= w_cnt_nxt;
         r_rx         <= w_rx_nxt;
         r_ss_n       <= w_ss_n_nxt;
         r_mosi       <= w_mosi_nxt;
         r_rsp_valid  <= w_rsp_valid_nxt;
         r_rsp_data   <= w_rsp_data_nxt;
         r_seq_err    <= w_seq_err_nxt;
         r_rd_pending <= w_rd_pending_nxt;
      end
   end

   // Pin values are computed one cycle ahead so SS_n/MOSI come straight from flops.
   always_comb begin
      w_state_nxt      = r_state;
      w_shift_nxt      = r_shift;
      w_cmd_nxt        = r_cmd;
      w_cnt_nxt        = r_cnt;
      w_rx_nxt         = r_rx;
      w_ss_n_nxt       = r_ss_n;
      w_mosi_nxt       = r_mosi;
      w_rsp_valid_nxt  = 1'b0;
      w_rsp_data_nxt   = r_rsp_data;
      w_seq_err_nxt    = r_seq_err;
      w_rd_pending_nxt = r_rd_pending;

      unique case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_state_nxt = S_START;
               w_shift_nxt = {req_cmd, req_data};
               w_cmd_nxt   = req_cmd;
               w_cnt_nxt   = '0;
               w_ss_n_nxt  = 1'b0;
               w_mosi_nxt  = req_cmd[1];
            end
         end
         S_START: begin
            w_state_nxt = S_SHIFT;
            w_mosi_nxt  = r_shift[9];
            w_shift_nxt = {r_shift[8:0], 1'b0};
            w_cnt_nxt   = '0;
         end
         S_SHIFT: begin
            if (r_cnt == C_SHIFT_LAST) begin
               w_mosi_nxt = 1'b0;
               w_cnt_nxt  = '0;
               if (r_cmd == 2'b11) begin
                  w_state_nxt = S_TURN;
               end else begin
                  w_state_nxt = S_GAP;
                  w_ss_n_nxt  = 1'b1;
                  if (r_cmd == 2'b10) begin
                     w_rd_pending_nxt = 1'b1;
                  end
               end
            end else begin
               w_mosi_nxt  = r_shift[9];
               w_shift_nxt = {r_shift[8:0], 1'b0};
               w_cnt_nxt   = r_cnt + C_ONE;
            end
         end
         S_TURN: begin
            if (r_cnt == C_TURN_LAST) begin
               w_state_nxt = S_CAPTURE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
            end
         end
         S_CAPTURE: begin
            w_rx_nxt  = {r_rx[6:0], MISO};
            w_cnt_nxt = r_cnt + C_ONE;
            if (r_cnt == C_CAP_LAST) begin
               w_state_nxt      = S_GAP;
               w_cnt_nxt        = '0;
               w_ss_n_nxt       = 1'b1;
               w_rsp_valid_nxt  = 1'b1;
               w_rsp_data_nxt   = {r_rx[6:0], MISO};
               w_seq_err_nxt    = r_seq_err | ~r_rd_pending;
               w_rd_pending_nxt = 1'b0;
            end
         end
         S_GAP: begin
            if (r_cnt == C_GAP_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_ss_n_nxt  = 1'b1;
            w_mosi_nxt  = 1'b0;
         end
      endcase
   end

   assign req_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign SS_n      = r_ss_n;
   assign MOSI      = r_mosi;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign seq_err   = r_seq_err;

endmodule
